// File: rtl/line_raster.sv
// Bresenham line rasterizer: accepts a clipped segment and streams its pixels
// with valid/ready handshaking, silently stepping over off-screen points.
module line_raster #(
    parameter logic signed [15:0] XMAX = 16'sd799,
    parameter logic signed [15:0] YMAX = 16'sd479
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] i_x1,
    input  logic signed [15:0] i_y1,
    input  logic signed [15:0] i_x2,
    input  logic signed [15:0] i_y2,
    input  logic               i_start,
    output logic               o_ready,
    output logic signed [15:0] o_px,
    output logic signed [15:0] o_py,
    output logic               o_valid,
    input  logic               i_pix_ready,
    output logic               o_done
);

    localparam int unsigned CW  = 16;
    localparam int unsigned DXW = CW + 1;
    localparam int unsigned EW  = CW + 2;
    localparam int unsigned E2W = CW + 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic signed [CW-1:0]  x1_q, y1_q, x2_q, y2_q;
    logic signed [CW-1:0]  x1_nxt, y1_nxt, x2_nxt, y2_nxt;
    logic [DXW-1:0]        dx_q, dx_nxt;
    logic signed [EW-1:0]  dy_q, dy_nxt;
    logic signed [EW-1:0]  err_q, err_nxt;
    logic                  sx_neg_q, sx_neg_nxt;
    logic                  sy_neg_q, sy_neg_nxt;
    logic signed [CW-1:0]  px_nxt, py_nxt;
    logic                  valid_nxt, ready_nxt, done_nxt;

    // Setup-phase arithmetic on the latched endpoints
    logic signed [DXW-1:0] ddx_c, ddy_c;
    logic [DXW-1:0]        adx_c, ady_c;
    logic signed [EW-1:0]  dy_setup_c, err_setup_c;

    // Single Bresenham step from the current point
    logic signed [E2W-1:0] e2_c;
    logic                  step_x_c, step_y_c;
    logic signed [EW-1:0]  err_step_c;
    logic signed [CW-1:0]  px_step_c, py_step_c;
    logic                  advance_c, at_end_c;

    function automatic logic on_screen(input logic signed [CW-1:0] x,
                                       input logic signed [CW-1:0] y);
        return (x >= 16'sd0) && (x <= XMAX) && (y >= 16'sd0) && (y <= YMAX);
    endfunction

    always_comb begin
        ddx_c       = DXW'(x2_q) - DXW'(x1_q);
        ddy_c       = DXW'(y2_q) - DXW'(y1_q);
        adx_c       = ddx_c[DXW-1] ? DXW'(-ddx_c) : DXW'(ddx_c);
        ady_c       = ddy_c[DXW-1] ? DXW'(-ddy_c) : DXW'(ddy_c);
        dy_setup_c  = -$signed({1'b0, ady_c});
        err_setup_c = $signed({1'b0, adx_c}) + dy_setup_c;
    end

    // Both axis decisions use the pre-step error term
    always_comb begin
        e2_c       = $signed({err_q, 1'b0});
        step_x_c   = e2_c >= E2W'(dy_q);
        step_y_c   = e2_c <= $signed({2'b00, dx_q});
        err_step_c = err_q;
        if (step_x_c) begin
            err_step_c = err_step_c + dy_q;
        end
        if (step_y_c) begin
            err_step_c = err_step_c + $signed({1'b0, dx_q});
        end
        px_step_c = o_px;
        py_step_c = o_py;
        if (step_x_c) begin
            px_step_c = sx_neg_q ? o_px - 16'sd1 : o_px + 16'sd1;
        end
        if (step_y_c) begin
            py_step_c = sy_neg_q ? o_py - 16'sd1 : o_py + 16'sd1;
        end
    end

    // An on-screen pixel waits for the consumer; an off-screen one moves on at once
    always_comb begin
        advance_c = (state == S_RUN) && (!o_valid || i_pix_ready);
        at_end_c  = (o_px == x2_q) && (o_py == y2_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_SETUP;
            S_SETUP: state_nxt = S_RUN;
            S_RUN:   if (advance_c && at_end_c) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        x1_nxt     = x1_q;
        y1_nxt     = y1_q;
        x2_nxt     = x2_q;
        y2_nxt     = y2_q;
        dx_nxt     = dx_q;
        dy_nxt     = dy_q;
        err_nxt    = err_q;
        sx_neg_nxt = sx_neg_q;
        sy_neg_nxt = sy_neg_q;
        px_nxt     = o_px;
        py_nxt     = o_py;
        valid_nxt  = 1'b0;
        ready_nxt  = (state_nxt == S_IDLE);
        done_nxt   = (state_nxt == S_DONE);
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    x1_nxt = i_x1;
                    y1_nxt = i_y1;
                    x2_nxt = i_x2;
                    y2_nxt = i_y2;
                end
            end
            S_SETUP: begin
                dx_nxt     = adx_c;
                dy_nxt     = dy_setup_c;
                err_nxt    = err_setup_c;
                sx_neg_nxt = ddx_c[DXW-1];
                sy_neg_nxt = ddy_c[DXW-1];
                px_nxt     = x1_q;
                py_nxt     = y1_q;
                valid_nxt  = on_screen(x1_q, y1_q);
            end
            S_RUN: begin
                if (!advance_c) begin
                    valid_nxt = o_valid;
                end else if (!at_end_c) begin
                    err_nxt   = err_step_c;
                    px_nxt    = px_step_c;
                    py_nxt    = py_step_c;
                    valid_nxt = on_screen(px_step_c, py_step_c);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1_q     <= '0;
            y1_q     <= '0;
            x2_q     <= '0;
            y2_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            o_px     <= '0;
            o_py     <= '0;
            o_valid  <= 1'b0;
            o_ready  <= 1'b1;
            o_done   <= 1'b0;
        end else begin
            x1_q     <= x1_nxt;
            y1_q     <= y1_nxt;
            x2_q     <= x2_nxt;
            y2_q     <= y2_nxt;
            dx_q     <= dx_nxt;
            dy_q     <= dy_nxt;
            err_q    <= err_nxt;
            sx_neg_q <= sx_neg_nxt;
            sy_neg_q <= sy_neg_nxt;
            o_px     <= px_nxt;
            o_py     <= py_nxt;
            o_valid  <= valid_nxt;
            o_ready  <= ready_nxt;
            o_done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_line_raster.sv
// Directed bench for line_raster: hand-computed pixel sequences, timing,
// backpressure, clipping, ignored starts and mid-line reset.
module tb_line_raster;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] i_x1, i_y1, i_x2, i_y2;
    logic               i_start;
    logic               o_ready;
    logic signed [15:0] o_px, o_py;
    logic               o_valid;
    logic               i_pix_ready;
    logic               o_done;

    int n_checks = 0;
    int n_err    = 0;
    int got_x[$];
    int got_y[$];
    int ex[8];
    int ey[8];
    int first_v;
    int done_c;

    line_raster dut (
        .clk         (clk),
        .rst         (rst),
        .i_x1        (i_x1),
        .i_y1        (i_y1),
        .i_x2        (i_x2),
        .i_y2        (i_y2),
        .i_start     (i_start),
        .o_ready     (o_ready),
        .o_px        (o_px),
        .o_py        (o_py),
        .o_valid     (o_valid),
        .i_pix_ready (i_pix_ready),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a line for one edge, then scrambles the inputs to prove they were latched
    task automatic start_line(input int x1, input int y1, input int x2, input int y2);
        check("ready_before_start", 32'(o_ready), 1);
        i_x1 = 16'(x1);
        i_y1 = 16'(y1);
        i_x2 = 16'(x2);
        i_y2 = 16'(y2);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_x1 = 16'sd999;
        i_y1 = 16'sd999;
        i_x2 = 16'sd333;
        i_y2 = 16'sd333;
    endtask

    // Called in the SETUP cycle; cycle 1 is the first RUN cycle
    task automatic collect(input int poke);
        got_x.delete();
        got_y.delete();
        first_v = -1;
        done_c  = -1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            i_start = (c == poke);
            if (o_valid) begin
                got_x.push_back(int'(o_px));
                got_y.push_back(int'(o_py));
                if (first_v < 0) first_v = c;
            end
            if (o_done) begin
                done_c = c;
                break;
            end
        end
        i_start = 1'b0;
        check("done_seen", 32'(done_c >= 0), 1);
    endtask

    task automatic check_pixels(input string tag, input int n);
        check({tag, "_count"}, 32'(got_x.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_x.size()) begin
                check($sformatf("%s_x%0d", tag, i), 32'(got_x[i]), 32'(ex[i]));
                check($sformatf("%s_y%0d", tag, i), 32'(got_y[i]), 32'(ey[i]));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        i_x1 = '0; i_y1 = '0; i_x2 = '0; i_y2 = '0;
        i_start = 1'b0;
        i_pix_ready = 1'b1;
        tick();
        check("rst_ready", 32'(o_ready), 1);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_done",  32'(o_done), 0);
        check("rst_px",    32'(o_px), 0);
        check("rst_py",    32'(o_py), 0);
        tick();
        rst = 1'b0;
        tick();

        // Horizontal line, cycle-exact timing
        start_line(0, 0, 3, 0);
        check("h_setup_ready", 32'(o_ready), 0);
        check("h_setup_valid", 32'(o_valid), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("h_valid%0d", i), 32'(o_valid), 1);
            check($sformatf("h_px%0d", i), 32'(o_px), 32'(i));
            check($sformatf("h_py%0d", i), 32'(o_py), 0);
        end
        tick();
        check("h_done",       32'(o_done), 1);
        check("h_done_valid", 32'(o_valid), 0);
        check("h_done_ready", 32'(o_ready), 0);
        tick();
        check("h_idle_ready", 32'(o_ready), 1);
        check("h_idle_done",  32'(o_done), 0);

        // Steep line
        start_line(0, 0, 1, 3);
        collect(0);
        ex = '{0, 0, 1, 1, 0, 0, 0, 0};
        ey = '{0, 1, 2, 3, 0, 0, 0, 0};
        check_pixels("steep", 4);
        tick();

        // Reversed diagonal
        start_line(5, 5, 2, 2);
        collect(0);
        ex = '{5, 4, 3, 2, 0, 0, 0, 0};
        ey = '{5, 4, 3, 2, 0, 0, 0, 0};
        check_pixels("rev", 4);
        tick();

        // Backpressure on the middle pixel
        start_line(0, 0, 2, 0);
        tick();
        check("bp_p0_x", 32'(o_px), 0);
        tick();
        i_pix_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_hold_valid%0d", i), 32'(o_valid), 1);
            check($sformatf("bp_hold_px%0d", i), 32'(o_px), 1);
            check($sformatf("bp_hold_py%0d", i), 32'(o_py), 0);
            if (i < 2) tick();
        end
        i_pix_ready = 1'b1;
        tick();
        check("bp_p2_valid", 32'(o_valid), 1);
        check("bp_p2_x", 32'(o_px), 2);
        tick();
        check("bp_done", 32'(o_done), 1);
        tick();

        // Clipping on the left edge
        start_line(-2, 0, 1, 0);
        collect(0);
        ex = '{0, 1, 0, 0, 0, 0, 0, 0};
        ey = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_pixels("clip", 2);
        check("clip_first_cycle", 32'(first_v), 3);
        tick();

        // Degenerate single point
        start_line(7, 9, 7, 9);
        collect(0);
        ex = '{7, 0, 0, 0, 0, 0, 0, 0};
        ey = '{9, 0, 0, 0, 0, 0, 0, 0};
        check_pixels("pt", 1);
        check("pt_done_cycle", 32'(done_c), 2);
        tick();

        // Start pulsed during RUN must be ignored
        start_line(0, 0, 20, 0);
        collect(5);
        check("long_count", 32'(got_x.size()), 21);
        if (got_x.size() == 21) begin
            check("long_last_x", 32'(got_x[20]), 20);
            check("long_mid_x",  32'(got_x[10]), 10);
        end
        tick();
        check("long_idle", 32'(o_ready), 1);
        tick();
        check("long_no_restart", 32'(o_ready), 1);

        // Reset on the third pixel
        start_line(0, 0, 10, 0);
        tick();
        tick();
        tick();
        check("rs_third_px", 32'(o_px), 2);
        rst = 1'b1;
        #1;
        check("rs_valid", 32'(o_valid), 0);
        check("rs_ready", 32'(o_ready), 1);
        check("rs_done",  32'(o_done), 0);
        tick();
        check("rs_done_hold", 32'(o_done), 0);
        rst = 1'b0;
        tick();
        check("rs_no_done", 32'(o_done), 0);
        start_line(4, 2, 6, 2);
        collect(0);
        ex = '{4, 5, 6, 0, 0, 0, 0, 0};
        ey = '{2, 2, 2, 0, 0, 0, 0, 0};
        check_pixels("after_rst", 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
